// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the ID-stage control bundle through the ID/EX, EX/MEM
// and MEM/WB pipeline registers of a 5-stage MIPS pipeline. It also resolves
// the EX destination register, detects load-use hazards, and drives the EX
// operand forwarding selects.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ctrl_i              ID bundle {ALUOp[1:0], RegDst, ALUSrc, MemtoReg,
//                       RegWrite, MemWrite, MemRead, Branch, Jump}
//   rs_i, rt_i, rd_i    ID instruction register fields
//   flush_i             squash the ID instruction (bubble into ID/EX)
//   ex_*                fields held in ID/EX (ex_dest_o is combinational)
//   mem_*               fields held in EX/MEM
//   wb_*                fields held in MEM/WB
//   stall_o             load-use hazard: PC and IF/ID hold
//   fwd_a_o, fwd_b_o    EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
module ctrl_pipe #(
    parameter int CTRL_W = 10,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              flush_i,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic [REG_W-1:0]  ex_dest_o,
    output logic              mem_mem_write_o,
    output logic              mem_mem_read_o,
    output logic              wb_mem_to_reg_o,
    output logic              wb_reg_write_o,
    output logic [REG_W-1:0]  wb_dest_o,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    typedef struct packed {
        logic [1:0]       alu_op;
        logic             reg_dst;
        logic             alu_src;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic [REG_W-1:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic             mem_to_reg;
        logic             reg_write;
        logic [REG_W-1:0] dest;
    } mem_wb_t;

    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic [REG_W-1:0] ex_dest;
    logic             stall;
    logic             bubble;
    id_ex_t           id_ex_next;

    assign ex_dest = id_ex.reg_dst ? id_ex.rd : id_ex.rt;

    // Conservative: rt is compared even when the ID instruction does not read it.
    assign stall = id_ex.mem_read && (ex_dest != '0) &&
                   ((ex_dest == rs_i) || (ex_dest == rt_i));

    // A stall and a flush in the same cycle still produce a single bubble.
    assign bubble = stall || flush_i;

    // Branch/Jump (bits [1:0]) are consumed in ID and not carried.
    always_comb begin
        id_ex_next            = '0;
        id_ex_next.alu_op     = ctrl_i[9:8];
        id_ex_next.reg_dst    = ctrl_i[7];
        id_ex_next.alu_src    = ctrl_i[6];
        id_ex_next.mem_to_reg = ctrl_i[5];
        id_ex_next.reg_write  = ctrl_i[4];
        id_ex_next.mem_write  = ctrl_i[3];
        id_ex_next.mem_read   = ctrl_i[2];
        id_ex_next.rs         = rs_i;
        id_ex_next.rt         = rt_i;
        id_ex_next.rd         = rd_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex             <= bubble ? id_ex_t'('0) : id_ex_next;
            ex_mem.mem_to_reg <= id_ex.mem_to_reg;
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.mem_read   <= id_ex.mem_read;
            ex_mem.dest       <= ex_dest;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.dest       <= ex_mem.dest;
        end
    end

    // EX/MEM is the newer producer, so it wins over MEM/WB; $0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (ex_mem.reg_write && ex_mem.dest != '0 && ex_mem.dest == src)
            return 2'b10;
        else if (mem_wb.reg_write && mem_wb.dest != '0 && mem_wb.dest == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a_o = fwd_sel(id_ex.rs);
    assign fwd_b_o = fwd_sel(id_ex.rt);

    assign ex_alu_op_o     = id_ex.alu_op;
    assign ex_alu_src_o    = id_ex.alu_src;
    assign ex_dest_o       = ex_dest;
    assign mem_mem_write_o = ex_mem.mem_write;
    assign mem_mem_read_o  = ex_mem.mem_read;
    assign wb_mem_to_reg_o = mem_wb.mem_to_reg;
    assign wb_reg_write_o  = mem_wb.reg_write;
    assign wb_dest_o       = mem_wb.dest;
    assign stall_o         = stall;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, propagation latency, load-use stall,
// forwarding priority, $0 guard, flush and reset mid-stream.
module tb_ctrl_pipe;

    localparam logic [9:0] NOP   = 10'h000;
    localparam logic [9:0] LW    = 10'h074;  // ALUSrc MemtoReg RegWrite MemRead
    localparam logic [9:0] RTYPE = 10'h290;  // ALUOp=10 RegDst RegWrite

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       flush;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src;
    logic [4:0] ex_dest;
    logic       mem_mem_write, mem_mem_read;
    logic       wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_dest;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;

    int total = 0;
    int passed = 0;

    ctrl_pipe #(.CTRL_W(10), .REG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .flush_i(flush),
        .ex_alu_op_o(ex_alu_op), .ex_alu_src_o(ex_alu_src), .ex_dest_o(ex_dest),
        .mem_mem_write_o(mem_mem_write), .mem_mem_read_o(mem_mem_read),
        .wb_mem_to_reg_o(wb_mem_to_reg), .wb_reg_write_o(wb_reg_write),
        .wb_dest_o(wb_dest), .stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs set before, outputs sampled 1ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic [9:0] c, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d);
        ctrl = c; rs = s; rt = t; rd = d;
    endtask

    task automatic drain();
        id(NOP, 0, 0, 0);
        flush = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        id(10'h324, 0, 0, 0);
        tick(); tick();
        chk("rst_ex_alu_op", 32'(ex_alu_op), 0);
        chk("rst_ex_alu_src", 32'(ex_alu_src), 0);
        chk("rst_ex_dest", 32'(ex_dest), 0);
        chk("rst_mem_rd_wr", 32'({mem_mem_read, mem_mem_write}), 0);
        chk("rst_wb", 32'({wb_mem_to_reg, wb_reg_write, wb_dest}), 0);
        chk("rst_stall_fwd", 32'({stall, fwd_a, fwd_b}), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_alu_op", 32'(ex_alu_op), 32'h3);
        drain();

        // lw $8 propagation
        id(LW, 1, 8, 0);
        tick();
        chk("lw_ex_alu_src", 32'(ex_alu_src), 1);
        chk("lw_ex_dest", 32'(ex_dest), 8);
        id(NOP, 0, 0, 0);
        tick();
        chk("lw_mem_read", 32'(mem_mem_read), 1);
        tick();
        chk("lw_wb", 32'({wb_mem_to_reg, wb_reg_write, wb_dest}), {25'd0, 2'b11, 5'd8});
        drain();

        // load-use: lw $8 then R-type reading $8
        id(LW, 0, 8, 0);
        tick();
        id(RTYPE, 8, 9, 10);
        #1;
        chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bubble_ex", 32'({ex_alu_op, ex_alu_src, ex_dest}), 0);
        chk("lu_stall_drop", 32'(stall), 0);
        chk("lu_lw_in_mem", 32'(mem_mem_read), 1);
        tick();
        chk("lu_ex_dest", 32'(ex_dest), 10);
        chk("lu_fwd_a", 32'(fwd_a), 32'b01);
        chk("lu_fwd_b", 32'(fwd_b), 0);
        drain();

        // forwarding priority: add $3 then two readers of $3
        id(RTYPE, 1, 2, 3);
        tick();
        id(RTYPE, 3, 4, 5);
        tick();
        chk("fwd_first", 32'(fwd_a), 32'b10);
        id(RTYPE, 3, 6, 7);
        tick();
        chk("fwd_second", 32'(fwd_a), 32'b01);
        drain();
        id(RTYPE, 1, 2, 3);
        tick();
        id(RTYPE, 0, 0, 3);
        tick();
        id(RTYPE, 3, 3, 9);
        tick();
        chk("fwd_newest_a", 32'(fwd_a), 32'b10);
        chk("fwd_newest_b", 32'(fwd_b), 32'b10);
        drain();

        // $0 guard
        id(RTYPE, 1, 2, 0);
        tick();
        id(RTYPE, 0, 0, 4);
        tick();
        chk("zero_fwd", 32'({fwd_a, fwd_b}), 0);
        drain();
        id(LW, 0, 0, 0);
        tick();
        id(RTYPE, 0, 0, 4);
        #1;
        chk("zero_stall", 32'(stall), 0);
        drain();

        // flush
        id(RTYPE, 1, 2, 11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        id(NOP, 0, 0, 0);
        chk("flush_ex", 32'({ex_alu_op, ex_alu_src, ex_dest}), 0);
        tick(); tick();
        chk("flush_wb_rw", 32'(wb_reg_write), 0);
        drain();

        // flush during stall: single bubble
        id(LW, 0, 8, 0);
        tick();
        id(RTYPE, 8, 2, 12);
        flush = 1'b1;
        #1;
        chk("fs_stall", 32'(stall), 1);
        tick();
        flush = 1'b0;
        chk("fs_bubble", 32'({ex_alu_op, ex_dest, stall}), 0);
        tick();
        chk("fs_reenter", 32'({ex_dest, stall, fwd_a}), {24'd0, 5'd12, 1'b0, 2'b01});
        drain();

        // reset mid-stream discards in-flight control
        id(LW, 0, 8, 0);
        tick();
        id(NOP, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mem", 32'({mem_mem_read, ex_alu_src, ex_dest}), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receives the 10-bit control bundle produced by the ID-stage decoder.
- Carries that bundle down the ID/EX, EX/MEM and MEM/WB pipeline registers and delivers each field to the stage that uses it.
- Also resolves the destination register, detects load-use hazards (stall plus bubble), and drives the EX-stage forwarding selects.
- Sits between the decoder and the datapath stage registers of the 5-stage MIPS pipeline.

Parameters:
CTRL_W, 10, width of the control bundle.
REG_W, 5, register-index width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
ctrl_i  in  CTRL_W  ID-stage bundle: [9:8] ALUOp, [7] RegDst, [6] ALUSrc, [5] MemtoReg, [4] RegWrite, [3] MemWrite, [2] MemRead, [1] Branch, [0] Jump
rs_i  in  REG_W  ID-stage instruction rs field
rt_i  in  REG_W  ID-stage instruction rt field
rd_i  in  REG_W  ID-stage instruction rd field
flush_i  in  1  squash the ID instruction (bubble into ID/EX)
ex_alu_op_o  out  2  ALUOp held in ID/EX
ex_alu_src_o  out  1  ALUSrc held in ID/EX
ex_dest_o  out  REG_W  EX destination: rd if RegDst, else rt
mem_mem_write_o  out  1  MemWrite held in EX/MEM
mem_mem_read_o  out  1  MemRead held in EX/MEM
wb_mem_to_reg_o  out  1  MemtoReg held in MEM/WB
wb_reg_write_o  out  1  RegWrite held in MEM/WB
wb_dest_o  out  REG_W  destination held in MEM/WB
stall_o  out  1  load-use hazard: PC and IF/ID must hold
fwd_a_o  out  2  EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB
fwd_b_o  out  2  EX operand B select, same encoding

Behaviour:
- Reset (rst_i=1 at an edge): every pipeline register goes to 0.
  - All registered outputs read 0.
  - stall_o=0 and fwd_a_o/fwd_b_o=00, because they are derived from the zeroed state.
  - Reset wins over flush_i and stall; a reset mid-stream discards all in-flight control.
- Bundle bits [1:0] (Branch, Jump) are resolved in ID and are not carried.
- ID/EX register holds: ALUOp, RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, rs, rt, rd.
  - ex_dest_o is combinational: RegDst ? rd : rt.
- EX/MEM register holds: MemtoReg, RegWrite, MemWrite, MemRead, dest.
- MEM/WB register holds: MemtoReg, RegWrite, dest.
- EX/MEM and MEM/WB advance every cycle unconditionally.
- Latency: a bundle at ctrl_i in cycle N appears at
  - ex_* in cycle N+1,
  - mem_* in cycle N+2,
  - wb_* in cycle N+3.
- Load-use hazard (combinational): stall_o = ID/EX.MemRead && ex_dest_o != 0 && (ex_dest_o == rs_i || ex_dest_o == rt_i).
  - The comparison is conservative; rt_i is compared regardless of the ID instruction type.
- Bubble: when stall_o or flush_i is 1, ID/EX loads all zeros (control and register fields) at the next edge instead of ctrl_i, rs_i, rt_i, rd_i.
  - Both stall_o=1 and flush_i=1 together: a single bubble. stall_o remains driven purely by the hazard equation.
  - The stalled instruction is re-presented by the holding IF/ID. After one bubble, ID/EX.MemRead=0, so stall_o deasserts automatically: exactly one stall cycle per load-use.
- Forwarding, A side (combinational from registered state):
  - If EX/MEM.RegWrite && EX/MEM.dest != 0 && EX/MEM.dest == ID/EX.rs, then 10.
  - Else if MEM/WB.RegWrite && MEM/WB.dest != 0 && MEM/WB.dest == ID/EX.rs, then 01.
  - Else 00.
  - EX/MEM has priority over MEM/WB when both match.
- Forwarding, B side: identical, using ID/EX.rt.
- Writes to $0 never forward and never stall.

Test Plan:
- Reset: rst_i=1 for 2 cycles with ctrl_i=10'h324 -> all outputs 0, stall_o=0, fwd=00. Then rst_i=0 -> ex_alu_op_o=2'b11 one cycle later.
- Propagation of lw (ctrl 10'h074, rt=8) in cycle 0 -> cycle 1 ex_alu_src_o=1, ex_dest_o=8; cycle 2 mem_mem_read_o=1; cycle 3 wb_mem_to_reg_o=1, wb_reg_write_o=1, wb_dest_o=8.
- Load-use: lw with rt=8, then R-type with rs=8 -> stall_o=1 for exactly one cycle, next ex_* all 0 (bubble). After the R-type re-enters, it gets fwd_a_o=01 when it reaches EX.
- Forward priority: add $3 (R-type, rd=3) followed by two instructions both reading $3 as rs -> first consumer fwd_a_o=10; second consumer fwd_a_o=01. With two back-to-back writers of $3, fwd_a_o=10 (newest wins).
- $0 guard: R-type with rd=0 then R-type with rs=0, rt=0 -> fwd_a_o=fwd_b_o=00. lw with rt=0 followed by rs=0 -> stall_o=0.
- Flush: flush_i=1 with ctrl_i=R-type -> next cycle ex_* zero and wb_reg_write_o=0 three cycles later. flush_i=1 during stall -> single bubble, no extra stall.
